// File: rtl/rotation_move_ctrl.sv
// -----------------------------------------------------------------------------
// rotation_move_ctrl
//
// Bus-programmed move sequencer for the quadrature rotation counter. The host
// programs a 16-bit target rotation count and a direction, then starts a move.
// The block enables the motor, counts full-rotation pulses coming from the
// counter, and stops once the target is reached. It then holds the motor
// disabled for a braking interval before reporting done. A stall (no pulse for
// too long) or a pulse in the wrong direction stops the move with a fault.
//
// Register map (offset from BASE_ADDR):
//   +0 CTRL      W: b0 start, b1 dir, b2 abort, b3 irq_en
//                R: {4'b0, irq_en, 1'b0, dir, 1'b0}
//   +1 STAT      R: {3'b0, aborted, fault_dir, fault_stall, done, busy}
//                   reading clears done / fault_dir / fault_stall / aborted
//   +2 TARGET_LO R/W  (writes ignored while busy)
//   +3 TARGET_HI R/W  (writes ignored while busy)
//   +4 COUNT_LO  R    (also snapshots COUNT[15:8] into a shadow register)
//   +5 COUNT_HI  R    (returns the shadow captured by the last COUNT_LO read)
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   addr       bus address
//   cs         bus chip select
//   rd         read strobe, qualified by cs
//   wr         write strobe, qualified by cs
//   data_in    bus write data
//   data_out   registered read data, holds between reads
//   rot_pulse  one-cycle pulse per full rotation
//   rot_dir    direction of that rotation (1 = CW), valid with rot_pulse
//   motor_en   registered motor drive enable
//   motor_dir  commanded direction (1 = CW), latched at move start
//   busy       high while moving or braking
//   irq        level interrupt: irq_en & (done | fault_stall | fault_dir)
// -----------------------------------------------------------------------------
module rotation_move_ctrl #(
    parameter logic [15:0] BASE_ADDR    = 16'h0040,
    parameter logic [23:0] STALL_CYCLES = 24'd1000000,
    parameter logic [15:0] BRAKE_CYCLES = 16'd1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic        cs,
    input  logic        rd,
    input  logic        wr,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    input  logic        rot_pulse,
    input  logic        rot_dir,
    output logic        motor_en,
    output logic        motor_dir,
    output logic        busy,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BRAKE = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    // -------------------------------------------------------------------------
    // Bus decode
    // -------------------------------------------------------------------------
    logic [15:0] offset;
    logic        wr_en;
    logic        rd_en;
    logic        sel_ctrl;
    logic        sel_stat;
    logic        sel_target_lo;
    logic        sel_target_hi;
    logic        sel_count_lo;
    logic        sel_count_hi;

    assign offset        = addr - BASE_ADDR;
    assign wr_en         = cs & wr;
    assign rd_en         = cs & rd;
    assign sel_ctrl      = (offset == 16'd0);
    assign sel_stat      = (offset == 16'd1);
    assign sel_target_lo = (offset == 16'd2);
    assign sel_target_hi = (offset == 16'd3);
    assign sel_count_lo  = (offset == 16'd4);
    assign sel_count_hi  = (offset == 16'd5);

    logic ctrl_wr;
    logic start_req;
    logic abort_req;
    logic stat_rd;

    // Abort has priority over start when both bits arrive in one write, so a
    // combined write never launches a move.
    assign ctrl_wr   = wr_en & sel_ctrl;
    assign abort_req = ctrl_wr & data_in[2];
    assign start_req = ctrl_wr & data_in[0] & ~data_in[2];
    assign stat_rd   = rd_en & sel_stat;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [15:0] target;
    logic [15:0] count;
    logic [7:0]  count_shadow;
    logic        dir_reg;
    logic        irq_en;
    logic        done;
    logic        fault_stall;
    logic        fault_dir;
    logic        aborted;
    logic [23:0] stall_cnt;
    logic [15:0] brake_cnt;

    // -------------------------------------------------------------------------
    // Rotation qualification
    // -------------------------------------------------------------------------
    logic        pulse_ok;
    logic        pulse_bad;
    logic [15:0] count_next;

    assign pulse_ok   = rot_pulse & (rot_dir == motor_dir);
    assign pulse_bad  = rot_pulse & (rot_dir != motor_dir);
    // COUNT saturates instead of wrapping; only an exact match with TARGET
    // ends a move, so a saturated count simply keeps running until stall/abort.
    assign count_next = (count == 16'hFFFF) ? count : count + 16'd1;

    // -------------------------------------------------------------------------
    // FSM next-state and per-cycle events
    // -------------------------------------------------------------------------
    logic move_start;
    logic count_step;
    logic done_set;
    logic fstall_set;
    logic fdir_set;
    logic abort_set;

    // NOTE: every output of this block gets a default before the case
    // statement, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        move_start = 1'b0;
        count_step = 1'b0;
        done_set   = 1'b0;
        fstall_set = 1'b0;
        fdir_set   = 1'b0;
        abort_set  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start_req) begin
                    if (target == 16'd0) begin
                        // A zero-length move completes immediately.
                        done_set = 1'b1;
                    end else begin
                        move_start = 1'b1;
                        next_state = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (abort_req) begin
                    abort_set  = 1'b1;
                    next_state = ST_BRAKE;
                end else if (pulse_bad) begin
                    fdir_set   = 1'b1;
                    next_state = ST_FAULT;
                end else if (pulse_ok) begin
                    count_step = 1'b1;
                    if (count_next == target) begin
                        next_state = ST_BRAKE;
                    end
                end else if (stall_cnt == STALL_CYCLES - 24'd1) begin
                    fstall_set = 1'b1;
                    next_state = ST_FAULT;
                end
            end

            ST_BRAKE: begin
                // Pulses are ignored here: the motor is coasting to a stop.
                if (brake_cnt == BRAKE_CYCLES - 16'd1) begin
                    done_set   = 1'b1;
                    next_state = ST_IDLE;
                end
            end

            ST_FAULT: begin
                // The host acknowledges the fault by reading STAT.
                if (stat_rd) begin
                    next_state = ST_IDLE;
                end
            end

            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    assign busy = (state == ST_RUN) || (state == ST_BRAKE);

    // -------------------------------------------------------------------------
    // Motor drive, counters and host-visible configuration
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            motor_en  <= 1'b0;
            motor_dir <= 1'b1;
            target    <= 16'd0;
            count     <= 16'd0;
            dir_reg   <= 1'b0;
            irq_en    <= 1'b0;
            stall_cnt <= 24'd0;
            brake_cnt <= 16'd0;
        end else begin
            // Registered enable: follows the state the FSM is entering.
            motor_en <= (next_state == ST_RUN);

            if (ctrl_wr) begin
                dir_reg <= data_in[1];
                irq_en  <= data_in[3];
            end

            if (wr_en && sel_target_lo && !busy) begin
                target[7:0] <= data_in;
            end
            if (wr_en && sel_target_hi && !busy) begin
                target[15:8] <= data_in;
            end

            if (move_start) begin
                count     <= 16'd0;
                motor_dir <= data_in[1];
            end else if (count_step) begin
                count <= count_next;
            end

            // Stall timer restarts on every good rotation.
            if (move_start || count_step) begin
                stall_cnt <= 24'd0;
            end else if (state == ST_RUN) begin
                stall_cnt <= stall_cnt + 24'd1;
            end

            if (state == ST_BRAKE) begin
                brake_cnt <= brake_cnt + 16'd1;
            end else begin
                brake_cnt <= 16'd0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Status flags: a set in the same cycle as a STAT read wins over the clear,
    // so an event is never lost between the read and the flag update.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            done        <= 1'b0;
            fault_stall <= 1'b0;
            fault_dir   <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            done        <= done_set   | (done        & ~stat_rd);
            fault_stall <= fstall_set | (fault_stall & ~stat_rd);
            fault_dir   <= fdir_set   | (fault_dir   & ~stat_rd);
            aborted     <= abort_set  | (aborted     & ~stat_rd);
        end
    end

    assign irq = irq_en & (done | fault_stall | fault_dir);

    // -------------------------------------------------------------------------
    // Read path. Values are sampled before this edge's updates, so a combined
    // read+write returns the pre-write contents.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out     <= 8'h00;
            count_shadow <= 8'h00;
        end else if (rd_en) begin
            if (sel_ctrl) begin
                data_out <= {4'b0000, irq_en, 1'b0, dir_reg, 1'b0};
            end else if (sel_stat) begin
                data_out <= {3'b000, aborted, fault_dir, fault_stall, done, busy};
            end else if (sel_target_lo) begin
                data_out <= target[7:0];
            end else if (sel_target_hi) begin
                data_out <= target[15:8];
            end else if (sel_count_lo) begin
                data_out     <= count[7:0];
                // Freeze the upper byte so a following hi read is coherent
                // with this lo read even if pulses arrive in between.
                count_shadow <= count[15:8];
            end else if (sel_count_hi) begin
                data_out <= count_shadow;
            end else begin
                data_out <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_rotation_move_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rotation_move_ctrl
//
// Testbench for rotation_move_ctrl. Bus reads push their expected data into a
// queue when issued; a monitor pops and compares when data_out becomes valid
// one cycle later. Other outputs are compared inline in each scenario task.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_rotation_move_ctrl;

    localparam logic [15:0] BASE      = 16'h0040;
    localparam logic [15:0] A_CTRL    = BASE + 16'd0;
    localparam logic [15:0] A_STAT    = BASE + 16'd1;
    localparam logic [15:0] A_TGT_LO  = BASE + 16'd2;
    localparam logic [15:0] A_TGT_HI  = BASE + 16'd3;
    localparam logic [15:0] A_CNT_LO  = BASE + 16'd4;
    localparam logic [15:0] A_CNT_HI  = BASE + 16'd5;
    localparam int          STALL     = 200;
    localparam int          BRAKE     = 1000;
    localparam int          WAIT_MAX  = 5000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = 16'h0000;
    logic        cs = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  data_out;
    logic        rot_pulse = 1'b0;
    logic        rot_dir = 1'b0;
    logic        motor_en;
    logic        motor_dir;
    logic        busy;
    logic        irq;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [7:0] exp_q[$];
    string      name_q[$];
    logic       rd_q = 1'b0;

    rotation_move_ctrl #(
        .BASE_ADDR   (BASE),
        .STALL_CYCLES(24'(STALL)),
        .BRAKE_CYCLES(16'(BRAKE))
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .cs       (cs),
        .rd       (rd),
        .wr       (wr),
        .data_in  (data_in),
        .data_out (data_out),
        .rot_pulse(rot_pulse),
        .rot_dir  (rot_dir),
        .motor_en (motor_en),
        .motor_dir(motor_dir),
        .busy     (busy),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Read scoreboard
    // -------------------------------------------------------------------------
    always @(posedge clk) rd_q <= cs & rd;

    always @(negedge clk) begin
        if (rd_q) begin
            n_compared++;
            if (exp_q.size() == 0) begin
                n_mismatched++;
                $display("FAIL read_unexpected: got %h with no expected value queued", data_out);
            end else begin
                logic [7:0] e;
                string      nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (data_out !== e) begin
                    n_mismatched++;
                    $display("FAIL %s: got %h want %h", nm, data_out, e);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus primitives: each starts and ends on a falling edge
    // -------------------------------------------------------------------------
    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        addr = a; data_in = d; cs = 1'b1; wr = 1'b1;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, input logic [7:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        addr = a; cs = 1'b1; rd = 1'b1;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic bus_rw(input logic [15:0] a, input logic [7:0] d,
                          input logic [7:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        addr = a; data_in = d; cs = 1'b1; rd = 1'b1; wr = 1'b1;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
    endtask

    task automatic pulse(input logic d);
        rot_dir = d; rot_pulse = 1'b1;
        @(negedge clk);
        rot_pulse = 1'b0;
    endtask

    // Counts falling edges (including the current one) while busy is high.
    task automatic wait_not_busy(output int n, output logic saw_en);
        n = 0;
        saw_en = 1'b0;
        while (busy && n < WAIT_MAX) begin
            if (motor_en) saw_en = 1'b1;
            n++;
            @(negedge clk);
        end
    endtask

    // -------------------------------------------------------------------------
    // Scenarios
    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_compared++;
        if ({motor_en, motor_dir, busy, irq} !== 4'b0100) begin
            n_mismatched++;
            $display("FAIL reset_outputs: got en/dir/busy/irq=%b want 0100",
                     {motor_en, motor_dir, busy, irq});
        end
        n_compared++;
        if (data_out !== 8'h00) begin
            n_mismatched++;
            $display("FAIL reset_data_out: got %h want 00", data_out);
        end
        rst = 1'b0;
        @(negedge clk);
        bus_read(A_STAT,   8'h00, "reset_stat");
        bus_read(A_CTRL,   8'h00, "reset_ctrl");
        bus_read(A_TGT_LO, 8'h00, "reset_target_lo");
        bus_read(A_CNT_LO, 8'h00, "reset_count_lo");
    endtask

    task automatic test_normal_move();
        int   n;
        logic saw_en;
        bus_write(A_TGT_LO, 8'h03);
        bus_write(A_TGT_HI, 8'h00);
        bus_read(A_TGT_LO, 8'h03, "t1_target_readback");
        bus_write(A_CTRL, 8'h03);
        n_compared++;
        if ({motor_en, motor_dir, busy} !== 3'b111) begin
            n_mismatched++;
            $display("FAIL t1_run_outputs: got en/dir/busy=%b want 111", {motor_en, motor_dir, busy});
        end
        pulse(1'b1); @(negedge clk);
        pulse(1'b1); @(negedge clk);
        n_compared++;
        if (motor_en !== 1'b1) begin
            n_mismatched++;
            $display("FAIL t1_still_running: got motor_en=%b want 1", motor_en);
        end
        pulse(1'b1);
        // Third pulse moved the FSM into BRAKE on that edge.
        wait_not_busy(n, saw_en);
        n_compared++;
        if (n != BRAKE || saw_en) begin
            n_mismatched++;
            $display("FAIL t1_brake_length: got %0d cycles (motor_en seen=%b) want %0d (0)",
                     n, saw_en, BRAKE);
        end
        n_compared++;
        if (irq !== 1'b0) begin
            n_mismatched++;
            $display("FAIL t1_irq_masked: got %b want 0", irq);
        end
        bus_read(A_STAT,   8'h02, "t1_stat_done");
        bus_read(A_STAT,   8'h00, "t1_stat_cleared");
        bus_read(A_CNT_LO, 8'h03, "t1_count_lo");
        bus_read(A_CNT_HI, 8'h00, "t1_count_hi");
    endtask

    task automatic test_zero_target();
        bus_write(A_TGT_LO, 8'h00);
        bus_write(A_CTRL, 8'h01);
        n_compared++;
        if ({motor_en, busy} !== 2'b00) begin
            n_mismatched++;
            $display("FAIL t2_no_motion: got en/busy=%b want 00", {motor_en, busy});
        end
        bus_read(A_STAT, 8'h02, "t2_stat_done");
    endtask

    task automatic test_dir_fault();
        int   n;
        logic saw_en;
        bus_write(A_TGT_LO, 8'h05);
        bus_write(A_CTRL, 8'h03);
        pulse(1'b0);
        n_compared++;
        if ({motor_en, busy} !== 2'b00) begin
            n_mismatched++;
            $display("FAIL t3_fault_outputs: got en/busy=%b want 00", {motor_en, busy});
        end
        bus_write(A_CTRL, 8'h03);
        n_compared++;
        if ({motor_en, busy} !== 2'b00) begin
            n_mismatched++;
            $display("FAIL t3_start_in_fault: got en/busy=%b want 00", {motor_en, busy});
        end
        bus_read(A_CNT_LO, 8'h00, "t3_count_unchanged");
        bus_read(A_STAT,   8'h08, "t3_stat_fault_dir");
        bus_read(A_STAT,   8'h00, "t3_stat_cleared");
        bus_write(A_CTRL, 8'h01);
        n_compared++;
        if ({motor_en, motor_dir, busy} !== 3'b101) begin
            n_mismatched++;
            $display("FAIL t3_restart_ccw: got en/dir/busy=%b want 101", {motor_en, motor_dir, busy});
        end
        bus_write(A_CTRL, 8'h04);
        wait_not_busy(n, saw_en);
        n_compared++;
        if (n >= WAIT_MAX) begin
            n_mismatched++;
            $display("FAIL t3_brake_timeout: got %0d cycles want < %0d", n, WAIT_MAX);
        end
        bus_read(A_STAT, 8'h12, "t3_stat_after_abort");
    endtask

    task automatic test_stall();
        int   n;
        logic saw_en;
        bus_write(A_TGT_LO, 8'h02);
        bus_write(A_CTRL, 8'h0B);
        wait_not_busy(n, saw_en);
        n_compared++;
        if (n != STALL) begin
            n_mismatched++;
            $display("FAIL t4_stall_time: got %0d cycles want %0d", n, STALL);
        end
        n_compared++;
        if ({irq, motor_en} !== 2'b10) begin
            n_mismatched++;
            $display("FAIL t4_irq_set: got irq/en=%b want 10", {irq, motor_en});
        end
        bus_read(A_STAT, 8'h04, "t4_stat_stall");
        n_compared++;
        if (irq !== 1'b0) begin
            n_mismatched++;
            $display("FAIL t4_irq_cleared: got %b want 0", irq);
        end
        bus_read(A_CTRL, 8'h0A, "t4_ctrl_readback");
        bus_write(A_CTRL, 8'h00);
    endtask

    task automatic test_abort();
        int   n;
        logic saw_en;
        bus_write(A_TGT_LO, 8'h04);
        bus_write(A_CTRL, 8'h03);
        pulse(1'b1);
        @(negedge clk);
        bus_read(A_CNT_LO, 8'h01, "t5_count_before_abort");
        bus_write(A_CTRL, 8'h04);
        n_compared++;
        if ({motor_en, busy} !== 2'b01) begin
            n_mismatched++;
            $display("FAIL t5_braking: got en/busy=%b want 01", {motor_en, busy});
        end
        bus_write(A_CTRL, 8'h03);
        bus_write(A_TGT_LO, 8'h09);
        n_compared++;
        if ({motor_en, busy} !== 2'b01) begin
            n_mismatched++;
            $display("FAIL t5_start_in_brake: got en/busy=%b want 01", {motor_en, busy});
        end
        pulse(1'b1);
        wait_not_busy(n, saw_en);
        n_compared++;
        if (n >= WAIT_MAX || saw_en) begin
            n_mismatched++;
            $display("FAIL t5_brake_end: got %0d cycles (motor_en seen=%b) want < %0d (0)",
                     n, saw_en, WAIT_MAX);
        end
        bus_read(A_STAT,   8'h12, "t5_stat_aborted");
        bus_read(A_CNT_LO, 8'h01, "t5_count_after_abort");
        bus_read(A_TGT_LO, 8'h04, "t5_target_protected");
        // Start and abort together: abort wins, nothing starts.
        bus_write(A_CTRL, 8'h05);
        n_compared++;
        if ({motor_en, busy} !== 2'b00) begin
            n_mismatched++;
            $display("FAIL t5_start_abort_combo: got en/busy=%b want 00", {motor_en, busy});
        end
        bus_read(A_STAT, 8'h00, "t5_combo_stat");
    endtask

    task automatic test_back_to_back();
        bus_write(A_TGT_LO, 8'h11);
        bus_rw(A_TGT_LO, 8'h22, 8'h11, "bb_rw_pre_write");
        bus_read(A_TGT_LO, 8'h22, "bb_after_write");
        bus_read(BASE + 16'd6, 8'h00, "bb_unmapped_hi");
        bus_read(16'h003F,     8'h00, "bb_unmapped_lo");
        bus_read(A_CNT_HI,     8'h00, "bb_count_hi_shadow");
    endtask

    task automatic test_snapshot_reset();
        bus_write(A_TGT_LO, 8'h05);
        bus_write(A_TGT_HI, 8'h01);
        bus_write(A_CTRL, 8'h03);
        repeat (255) begin
            pulse(1'b1);
            @(negedge clk);
        end
        bus_read(A_CNT_LO, 8'hFF, "t6_count_lo_ff");
        pulse(1'b1);
        @(negedge clk);
        bus_read(A_CNT_HI, 8'h00, "t6_hi_matches_snapshot");
        bus_read(A_CNT_LO, 8'h00, "t6_count_lo_wrapped_byte");
        bus_read(A_CNT_HI, 8'h01, "t6_hi_new_snapshot");
        n_compared++;
        if ({motor_en, busy} !== 2'b11) begin
            n_mismatched++;
            $display("FAIL t6_running_before_reset: got en/busy=%b want 11", {motor_en, busy});
        end
        rst = 1'b1;
        @(negedge clk);
        n_compared++;
        if ({motor_en, motor_dir, busy, irq} !== 4'b0100 || data_out !== 8'h00) begin
            n_mismatched++;
            $display("FAIL t6_reset_mid_run: got en/dir/busy/irq=%b data_out=%h want 0100 00",
                     {motor_en, motor_dir, busy, irq}, data_out);
        end
        rst = 1'b0;
        @(negedge clk);
        bus_read(A_TGT_LO, 8'h00, "t6_target_cleared");
        bus_read(A_TGT_HI, 8'h00, "t6_target_hi_cleared");
        bus_read(A_CNT_LO, 8'h00, "t6_count_cleared");
        bus_read(A_STAT,   8'h00, "t6_stat_cleared");
    endtask

    // -------------------------------------------------------------------------
    // Sequence
    // -------------------------------------------------------------------------
    initial begin
        @(negedge clk);
        test_reset();
        test_normal_move();
        test_zero_target();
        test_dir_fault();
        test_stall();
        test_abort();
        test_back_to_back();
        test_snapshot_reset();
        repeat (3) @(negedge clk);
        n_compared++;
        if (exp_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL read_queue_drain: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
